// File: rtl/ttl_pkg.sv
// ttl_pkg: shared constants and modulo next-state helper for TTL-style counters.
// Exports TTL_UP/TTL_DOWN, TTL_MAX_W and ttl_mod_next().
package ttl_pkg;

  localparam logic TTL_UP   = 1'b1;
  localparam logic TTL_DOWN = 1'b0;

  // widest counter the helper supports
  localparam int TTL_MAX_W = 32;

  typedef logic [TTL_MAX_W-1:0] ttl_q_t;
  typedef logic [TTL_MAX_W:0]   ttl_mod_t;

  // Returns {wrap, next_q} for one counting edge.
  // Up treats anything at or past the last state as terminal,
  // so out-of-range values fold back to 0.
  // Down only wraps at 0; out-of-range values just decrement.
  function automatic ttl_mod_t ttl_mod_next(
    input ttl_q_t   q,
    input logic     up_dn,
    input ttl_mod_t modulus
  );
    ttl_mod_t q_x;
    ttl_mod_t last;
    ttl_mod_t res;
    q_x  = {1'b0, q};
    last = modulus - ttl_mod_t'(1);
    res  = '0;
    if (up_dn == TTL_UP) begin
      if (q_x >= last) res = {1'b1, ttl_q_t'(0)};
      else             res = {1'b0, q + ttl_q_t'(1)};
    end else begin
      if (q == '0) res = {1'b1, last[TTL_MAX_W-1:0]};
      else         res = {1'b0, q - ttl_q_t'(1)};
    end
    return res;
  endfunction

endpackage

// File: rtl/ttl_sync_counter.sv
// ttl_sync_counter: synchronous modulo-N up/down counter, LS161/163 cascade semantics.
// Ports: clk, n_clr, din, n_load, enp, ent, up_dn -> q, rco, wrap.
module ttl_sync_counter
  import ttl_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MODULUS = 2**WIDTH
) (
  input  logic             clk,
  input  logic             n_clr,
  input  logic [WIDTH-1:0] din,
  input  logic             n_load,
  input  logic             enp,
  input  logic             ent,
  input  logic             up_dn,
  output logic [WIDTH-1:0] q,
  output logic             rco,
  output logic             wrap
);

  localparam ttl_mod_t         MOD_X = ttl_mod_t'(MODULUS);
  localparam logic [WIDTH-1:0] LAST  = WIDTH'(MODULUS - 1);

  ttl_mod_t nxt;
  logic     tc;

  assign nxt = ttl_mod_next(ttl_q_t'(q), up_dn, MOD_X);

  // terminal count looks only at q/up_dn; rco gated by ent only
  assign tc  = (up_dn == TTL_UP) ? (q >= LAST) : (q == '0);
  assign rco = tc & ent;

  always_ff @(posedge clk) begin
    if (!n_clr) begin
      q    <= '0;
      wrap <= 1'b0;
    end else if (!n_load) begin
      q    <= din;
      wrap <= 1'b0;
    end else if (enp & ent) begin
      q    <= nxt[WIDTH-1:0];
      wrap <= nxt[TTL_MAX_W];
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ttl_sync_counter.sv
// tb_ttl_sync_counter: scoreboard bench for ttl_sync_counter.
// Decade counter instance plus a two-stage 4-bit cascade.
module tb_ttl_sync_counter;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       n_clr, n_load, enp, ent, up_dn;
  logic [7:0] din;
  logic [7:0] q;
  logic       rco, wrap;

  ttl_sync_counter #(.WIDTH(8), .MODULUS(10)) u_dut (
    .clk(clk), .n_clr(n_clr), .din(din), .n_load(n_load),
    .enp(enp), .ent(ent), .up_dn(up_dn),
    .q(q), .rco(rco), .wrap(wrap)
  );

  logic       c_clr, c_enp;
  logic       c_one = 1'b1;
  logic [3:0] c_din = 4'h0;
  logic [3:0] lo_q, hi_q;
  logic       lo_rco, hi_rco, lo_wrap, hi_wrap;

  ttl_sync_counter #(.WIDTH(4), .MODULUS(16)) u_lo (
    .clk(clk), .n_clr(c_clr), .din(c_din), .n_load(c_one),
    .enp(c_enp), .ent(c_one), .up_dn(c_one),
    .q(lo_q), .rco(lo_rco), .wrap(lo_wrap)
  );

  ttl_sync_counter #(.WIDTH(4), .MODULUS(16)) u_hi (
    .clk(clk), .n_clr(c_clr), .din(c_din), .n_load(c_one),
    .enp(c_enp), .ent(lo_rco), .up_dn(c_one),
    .q(hi_q), .rco(hi_rco), .wrap(hi_wrap)
  );

  typedef struct {
    int   q;
    logic w;
    logic r;
  } exp_t;

  exp_t sb[$];
  int   c_sb[$];
  int   checks = 0;
  int   errors = 0;

  int   mq = 0;
  logic mw = 1'b0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model of one decade-counter edge
  function automatic void model(input logic c, input logic l,
                                input logic p, input logic t,
                                input logic u, input logic [7:0] d);
    if (!c) begin
      mq = 0; mw = 1'b0;
    end else if (!l) begin
      mq = int'(d); mw = 1'b0;
    end else if (p && t) begin
      if (u) begin
        if (mq >= 9) begin mq = 0; mw = 1'b1; end
        else begin mq = mq + 1; mw = 1'b0; end
      end else begin
        if (mq == 0) begin mq = 9; mw = 1'b1; end
        else begin mq = mq - 1; mw = 1'b0; end
      end
    end else begin
      mw = 1'b0;
    end
  endfunction

  task automatic drive(input logic c, input logic l, input logic p,
                       input logic t, input logic u,
                       input logic [7:0] d, input string tag);
    exp_t e;
    n_clr = c; n_load = l; enp = p; ent = t; up_dn = u; din = d;
    model(c, l, p, t, u, d);
    e.q = mq;
    e.w = mw;
    e.r = t & (u ? (mq >= 9) : (mq == 0));
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_q"}, 32'(q), 32'(e.q));
      check({tag, "_wrap"}, 32'(wrap), 32'(e.w));
      check({tag, "_rco"}, 32'(rco), 32'(e.r));
    end
  endtask

  initial begin
    int cnt;
    int exp_v;
    n_clr = 1'b1; n_load = 1'b1; enp = 1'b0; ent = 1'b0;
    up_dn = 1'b1; din = 8'h00;
    c_clr = 1'b1; c_enp = 1'b0;
    @(posedge clk);
    #1;

    // clear beats load and count
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h55, "clr");

    // decade count up: 1..9 then 0 with wrap
    for (int i = 0; i < 10; i++)
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, "up");

    // up_dn flips rco at once, q untouched
    up_dn = 1'b0;
    #1;
    check("updn_rco", 32'(rco), 32'd1);
    check("updn_q", 32'(q), 32'd0);

    // down wrap from 0
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, "ld0");
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, "dnwrap");
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, "dn");

    // out-of-range load
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hC8, "ldoor");
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, "oorup");
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hC8, "ldoor2");
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, "oordn");

    // enables
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h09, "ld9");
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, "enp0");
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, "ent0");

    // mid-operation clear at q=5
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, "clr2");
    for (int i = 0; i < 5; i++)
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, "cnt5");
    check("at5", 32'(q), 32'd5);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, "midclr");
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, "resume");

    // cascade: two 4-bit stages as one mod-256 counter
    c_clr = 1'b0;
    c_enp = 1'b0;
    @(posedge clk);
    #1;
    check("c_clr", 32'({hi_q, lo_q}), 32'd0);
    c_clr = 1'b1;
    c_enp = 1'b1;
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      cnt = (cnt + 1) % 256;
      c_sb.push_back(cnt);
      @(posedge clk);
      #1;
      exp_v = c_sb.pop_front();
      check("c_val", 32'({hi_q, lo_q}), 32'(exp_v));
      check("c_hiwrap", 32'(hi_wrap), (exp_v == 0) ? 32'd1 : 32'd0);
    end
    c_enp = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
